// File: rtl/cla_seq_adder.sv
// Byte-serial adder that reuses one 8-bit carry-lookahead adder over NBYTES cycles.
// Optional subtract mode (port sub) is enabled by defining CLA_SEQ_SUB_EN.

module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of generate terms masked by the propagates above them
    always_comb begin
        c    = '0;
        pp   = 1'b1;
        c[0] = ci;
        for (int i = 1; i <= 8; i++) begin
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp   = pp & p[j];
            end
            c[i] = c[i] | (ci & pp);
        end
    end

    assign s  = p ^ c[7:0];
    assign co = c[8];
endmodule

module cla_seq_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned KW = $clog2(NBYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          start_ready_q, start_ready_d;
    logic          res_valid_q, res_valid_d;
    logic          busy_q, busy_d;

    logic [7:0]    byte_a, byte_b, byte_b_eff, cla_s;
    logic          cla_co;
    logic          carry_init;

    assign byte_a = a_q[{k_q, 3'b000} +: 8];
    assign byte_b = b_q[{k_q, 3'b000} +: 8];

`ifdef CLA_SEQ_SUB_EN
    logic sub_q, sub_d;
    assign byte_b_eff = sub_q ? ~byte_b : byte_b;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign byte_b_eff = byte_b;
    assign carry_init = cin;
`endif

    cla8 u_cla8 (
        .a  (byte_a),
        .b  (byte_b_eff),
        .ci (carry_q),
        .s  (cla_s),
        .co (cla_co)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef CLA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    k_d     = '0;
                    carry_d = carry_init;
`ifdef CLA_SEQ_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{k_q, 3'b000} +: 8] = cla_s;
                carry_d = cla_co;
                k_d     = KW'(k_q + 1'b1);
                if (k_q == KW'(NBYTES - 1)) begin
                    k_d     = '0;
                    cout_d  = cla_co;
                    // Top byte carries the operand sign bits as presented to the adder
                    ovf_d   = (byte_a[7] == byte_b_eff[7]) && (cla_s[7] != byte_a[7]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        start_ready_d = (state_d == IDLE);
        res_valid_d   = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sum_q         <= sum_d;
            carry_q       <= carry_d;
            cout_q        <= cout_d;
            ovf_q         <= ovf_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
`ifdef CLA_SEQ_SUB_EN
            sub_q         <= sub_d;
`endif
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (NBYTES=4) with hand-computed expected results.
`timescale 1ns/1ps

module tb_cla_seq_adder;
    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [31:0]   a, b;
    logic          cin;
    logic          sub;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   sum;
    logic          cout, ovf, busy;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, scramble inputs after acceptance, wait for the result
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                         input logic [31:0] es, input logic ec, input logic eo, input string tag);
        int n;
        a = ta; b = tb_; cin = tc; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; a = ~ta; b = 32'h5A5A_5A5A; cin = ~tc;
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(NB));
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    task automatic release_res(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_rv_drop"}, 64'(res_valid), 64'(0));
        chk({tag, "_idle_ready"}, 64'(start_ready), 64'(1));
    endtask

    logic [31:0] bb_a [3];
    logic [31:0] bb_b [3];
    logic        bb_c [3];
    logic [31:0] bb_s [3];
    logic        bb_co[3];
    logic        bb_ov[3];

    initial begin
        int seen, idx_in, idx_out, last;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 64'(1));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // All-carry propagate through every byte
        do_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "carry_chain");
        release_res("carry_chain");

        // Positive overflow
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
        release_res("pos_ovf");

        // Hold the result for 10 cycles with a competing request pending
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, "stall");
        start_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rv", 64'(res_valid), 64'(1));
            chk("stall_sum", 64'(sum), 64'(32'hACF1_3568));
            chk("stall_sr", 64'(start_ready), 64'(0));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; start_valid = 1'b0;
        chk("stall_exit_busy", 64'(busy), 64'(0));
        chk("stall_exit_sr", 64'(start_ready), 64'(1));
        chk("stall_exit_rv", 64'(res_valid), 64'(0));
        chk("stall_exit_sum", 64'(sum), 64'(32'hACF1_3568));

        // Reset two cycles into a run
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_sr", 64'(start_ready), 64'(1));
        chk("midrst_rv", 64'(res_valid), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        chk("midrst_ovf", 64'(ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("midrst_no_result", 64'(seen), 64'(0));
        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "post_rst");
        release_res("post_rst");

        // Back-to-back with start_valid and res_ready held high
        bb_a[0] = 32'h0000_0003; bb_b[0] = 32'h0000_0004; bb_c[0] = 1'b1;
        bb_s[0] = 32'h0000_0008; bb_co[0] = 1'b0; bb_ov[0] = 1'b0;
        bb_a[1] = 32'h8000_0000; bb_b[1] = 32'h8000_0000; bb_c[1] = 1'b0;
        bb_s[1] = 32'h0000_0000; bb_co[1] = 1'b1; bb_ov[1] = 1'b1;
        bb_a[2] = 32'hFFFF_FFFF; bb_b[2] = 32'h0000_0000; bb_c[2] = 1'b1;
        bb_s[2] = 32'h0000_0000; bb_co[2] = 1'b1; bb_ov[2] = 1'b0;
        idx_in = 0; idx_out = 0; last = 0;
        a = bb_a[0]; b = bb_b[0]; cin = bb_c[0];
        start_valid = 1'b1; res_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && idx_out < 3; cyc++) begin
            @(negedge clk);
            if (res_valid) begin
                chk("b2b_sum", 64'(sum), 64'(bb_s[idx_out]));
                chk("b2b_cout", 64'(cout), 64'(bb_co[idx_out]));
                chk("b2b_ovf", 64'(ovf), 64'(bb_ov[idx_out]));
                if (idx_out > 0) chk("b2b_period", 64'(cyc - last), 64'(NB + 2));
                last = cyc;
                idx_out++;
            end
            if (start_ready) begin
                idx_in++;
                if (idx_in < 3) begin
                    a = bb_a[idx_in]; b = bb_b[idx_in]; cin = bb_c[idx_in];
                end else begin
                    start_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", 64'(idx_out), 64'(3));
        start_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);

`ifdef CLA_SEQ_SUB_EN
        // Subtract mode ignores cin
        sub = 1'b1;
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub");
        sub = 1'b0;
        release_res("sub");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
